// File: rtl/dmem_pkg.sv
// dmem_ctrl shared definitions: RV32I load/store funct3 codes
// and controller state encoding.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a core and the data memory.
// master = requester, slave = dmem_ctrl.
interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ram.sv
// DEPTH x 32 storage, byte-enable synchronous write and
// synchronous read on a single shared address.
module dmem_ram #(
  parameter  int DEPTH = 128,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Per-byte write and registered read (read returns old data).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// RV32I data memory controller: one-cycle load/store responses.
// Optional macro DMEM_CLEAR_EN: zero the array after each reset.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  output logic  busy,
  dmem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t state, state_n;

  logic             fire;
  logic             err;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be_req;
  logic [31:0]      wd_req;

  logic [3:0]       ram_be;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  logic             rsp_q;
  logic             err_q;
  logic             load_q;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic [31:0]      sh;
  logic [31:0]      ld;

  assign lane = bus.req_addr[1:0];
  assign idx  = bus.req_addr[IDX_W+1:2];

  assign bus.req_ready = (state == READY) && !rst;
  assign fire = bus.req_valid && bus.req_ready;

`ifdef DMEM_CLEAR_EN
  logic [IDX_W-1:0] clr_idx;

  // Sweep pointer; wraps back to 0 on the final word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
  end
`endif

  // State register; reset target depends on clearing support.
  always_ff @(posedge clk or posedge rst) begin
`ifdef DMEM_CLEAR_EN
    if (rst) state <= CLEAR;
`else
    if (rst) state <= READY;
`endif
    else state <= state_n;
  end

  // Decode access legality, byte enables and lane-replicated data.
  always_comb begin
    err    = (bus.req_addr >> (IDX_W + 2)) != '0;
    be_req = 4'b0000;
    wd_req = bus.req_wdata;
    if (bus.req_we) begin
      unique case (bus.req_funct3)
        F3_SB: begin
          be_req = 4'b0001 << lane;
          wd_req = {4{bus.req_wdata[7:0]}};
        end
        F3_SH: begin
          err    = err | lane[0];
          be_req = 4'b0011 << lane;
          wd_req = {2{bus.req_wdata[15:0]}};
        end
        F3_SW: begin
          err    = err | (lane != 2'b00);
          be_req = 4'b1111;
        end
        default: err = 1'b1;
      endcase
    end else begin
      unique case (bus.req_funct3)
        F3_LB, F3_LBU: ;
        F3_LH, F3_LHU: err = err | lane[0];
        F3_LW:         err = err | (lane != 2'b00);
        default:       err = 1'b1;
      endcase
    end
  end

  // Next state, busy flag and RAM port steering.
  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = idx;
    ram_wdata = wd_req;
    unique case (state)
      CLEAR: begin
`ifdef DMEM_CLEAR_EN
        busy      = 1'b1;
        ram_be    = 4'b1111;
        ram_addr  = clr_idx;
        ram_wdata = '0;
        if (clr_idx == IDX_W'(DEPTH - 1)) state_n = READY;
`else
        state_n = READY;
`endif
      end
      READY: begin
        if (fire && bus.req_we && !err) ram_be = be_req;
      end
      default: state_n = READY;
    endcase
  end

  dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Response stage; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q  <= 1'b0;
      err_q  <= 1'b0;
      load_q <= 1'b0;
      f3_q   <= 3'b000;
      lane_q <= 2'b00;
    end else begin
      rsp_q  <= fire;
      err_q  <= fire && err;
      load_q <= fire && !bus.req_we;
      f3_q   <= bus.req_funct3;
      lane_q <= lane;
    end
  end

  assign sh = ram_rdata >> {lane_q, 3'b000};

  // Extract and extend the addressed bytes.
  always_comb begin
    ld = '0;
    unique case (f3_q)
      F3_LB:   ld = {{24{sh[7]}}, sh[7:0]};
      F3_LBU:  ld = {24'h0, sh[7:0]};
      F3_LH:   ld = {{16{sh[15]}}, sh[15:0]};
      F3_LHU:  ld = {16'h0, sh[15:0]};
      F3_LW:   ld = sh;
      default: ld = '0;
    endcase
  end

  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = (rsp_q && load_q && !err_q) ? ld : '0;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The module SHALL have parameter DEPTH, default 128, meaning number of 32-bit words (power of 2, >=2).
REQ-002 The module SHALL have parameter ADDR_W, default 32, meaning byte-address width (>= clog2(DEPTH)+2).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 The module SHALL have port req_valid, input, 1, request present.
REQ-006 The module SHALL have port req_ready, output, 1, request accepted when req_valid & req_ready.
REQ-007 The module SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-008 The module SHALL have port req_addr, input, ADDR_W, RISC-V byte address.
REQ-009 The module SHALL have port req_funct3, input, 3, RV32I load/store funct3.
REQ-010 The module SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 The module SHALL have port rsp_valid, output, 1, one-cycle response pulse.
REQ-012 The module SHALL have port rsp_rdata, output, 32, load result, extended per funct3.
REQ-013 The module SHALL have port rsp_err, output, 1, access fault for the responded request.
REQ-014 The module SHALL have port busy, output, 1, high while clearing.

Function
REQ-015 FSM states SHALL be CLEAR and READY; req_ready SHALL equal (state==READY).
REQ-016 Every accepted request SHALL produce exactly one response: rsp_valid=1 on the next cycle, with rsp_rdata/rsp_err valid that cycle; back-to-back requests SHALL be accepted every cycle.
REQ-017 Word index SHALL be req_addr[clog2(DEPTH)+1:2]; byte lane SHALL be req_addr[1:0]; little-endian.
REQ-018 Stores: SB(000) writes 1 byte at lane, SH(001) writes 2 bytes at lane, SW(010) writes 4 bytes; other bytes SHALL be unchanged.
REQ-019 Loads: LB(000)/LH(001) SHALL sign-extend; LBU(100)/LHU(101) SHALL zero-extend; LW(010) returns the full word.
REQ-020 rsp_err SHALL be 1 and the access SHALL have no memory effect when: halfword with addr[0]=1; word with addr[1:0]!=0; any req_addr bit at or above clog2(DEPTH)+2 set; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-021 On error, and on store responses, rsp_rdata SHALL be 0.
REQ-022 A load accepted the cycle after a store to the same word SHALL return the updated data.
REQ-023 When rsp_valid=0, rsp_rdata and rsp_err SHALL be 0.

Reset
REQ-024 While rst=1: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0; any in-flight response SHALL be dropped.
REQ-025 On rst deassertion the FSM SHALL enter CLEAR if DMEM_CLEAR_EN is defined, else READY.
REQ-026 Reset asserted during CLEAR SHALL restart the sweep at word 0.

Configuration
REQ-027 Macro DMEM_CLEAR_EN defined: CLEAR SHALL zero one word per cycle, indices 0..DEPTH-1, busy=1 for exactly DEPTH cycles, then enter READY.
REQ-028 DMEM_CLEAR_EN undefined: no CLEAR state is entered, busy SHALL be constant 0, and memory contents SHALL survive reset.

Structure
REQ-029 Package dmem_pkg SHALL hold the funct3 constants (LB..LHU, SB..SW) and the state enum.
REQ-030 Sub-module dmem_ram SHALL be the DEPTH x 32 array with a 4-bit byte-enable synchronous write and a synchronous read, holding no control logic.

Verification
REQ-031 After reset with DMEM_CLEAR_EN, DEPTH=128: busy=1 and req_ready=0 for 128 cycles, then LW 0x1FC -> rsp_rdata=0x00000000.
REQ-032 SW 0x10 data 0x8899AABB; SB 0x11 data 0x55; LW 0x10 -> 0x889955BB; LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088.
REQ-033 SH 0x22 data 0x0000F00D; LH 0x22 -> 0xFFFFF00D; LHU 0x22 -> 0x0000F00D; LW 0x20 -> 0xF00D0000.
REQ-034 LW 0x02, SH 0x01, LW 0x200 (DEPTH=128), funct3=011 -> each rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-035 Back-to-back SW 0x40 data 0x12345678 then LW 0x40 on consecutive cycles -> two rsp_valid pulses, second rsp_rdata=0x12345678.
REQ-036 rst pulsed at clear cycle 60 -> busy remains 1 for 128 further cycles; rst pulsed with a load in flight -> no rsp_valid.
